// File: rtl/vstu_b_tracker_pkg.sv
// Shared types and helpers for the vector store B-response tracker.
// Holds the default sizing and the index-width helper.
package vstu_b_tracker_pkg;

  localparam int unsigned DefNrVInsn    = 8;
  localparam int unsigned DefQueueDepth = 4;
  localparam int unsigned DefCntWidth   = 12;

  function automatic int unsigned idx_width(
    input int unsigned num
  );
    return (num > 32'd1) ? $clog2(num) : 32'd1;
  endfunction

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RespOkay   = 2'b00;
  localparam axi_resp_t RespExOkay = 2'b01;
  localparam axi_resp_t RespSlvErr = 2'b10;
  localparam axi_resp_t RespDecErr = 2'b11;

endpackage

// File: rtl/vstu_b_tracker.sv
// Matches in-order AXI B beats against per-store AW burst counts.
// Retires a store only once every one of its bursts is acknowledged.
module vstu_b_tracker
  import vstu_b_tracker_pkg::*;
#(
  parameter int unsigned NrVInsn    = DefNrVInsn,
  parameter int unsigned QueueDepth = DefQueueDepth,
  parameter int unsigned CntWidth   = DefCntWidth,
  localparam int unsigned IdW       = idx_width(NrVInsn),
  localparam int unsigned QW        = idx_width(QueueDepth)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           aw_valid_i,
  output logic           aw_ready_o,
  input  logic [IdW-1:0] aw_id_i,
  input  logic           aw_last_i,
  input  logic           b_valid_i,
  input  logic [1:0]     b_resp_i,
  output logic           b_ready_o,
  output logic           done_valid_o,
  output logic [IdW-1:0] done_id_o,
  output logic           done_err_o,
  output logic           pending_o
);

  typedef struct packed {
    logic [IdW-1:0]      id;
    logic [CntWidth-1:0] outstanding;
    logic                closed;
    logic                err;
  } entry_t;

  localparam logic [QW:0]   Full   = (QW+1)'(QueueDepth);
  localparam logic [QW-1:0] LastIx = QW'(QueueDepth - 1);

  function automatic logic [QW-1:0] wrap_inc(
    input logic [QW-1:0] p
  );
    return (p == LastIx) ? '0 : p + 1'b1;
  endfunction

  entry_t        q_q [QueueDepth];
  entry_t        q_d [QueueDepth];
  logic [QW-1:0] head_q, head_d;
  logic [QW-1:0] tail_q, tail_d;
  logic [QW:0]   count_q, count_d;
  logic          tail_open_q, tail_open_d;

  logic           done_valid_d;
  logic [IdW-1:0] done_id_d;
  logic           done_err_d;

  logic aw_fire, b_fire, b_err;

  assign aw_ready_o = tail_open_q || (count_q != Full);
  assign b_ready_o  = (count_q != '0) &&
                      (q_q[head_q].outstanding != '0);
  assign pending_o  = (count_q != '0) || tail_open_q;

  assign aw_fire = aw_valid_i && aw_ready_o;
  assign b_fire  = b_valid_i && b_ready_o;
  assign b_err   = b_resp_i inside {RespSlvErr, RespDecErr};

  always_comb begin
    q_d          = q_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    tail_open_d  = tail_open_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_o;
    done_err_d   = done_err_o;

    // AW is applied before B so a same-entry pair nets to zero.
    if (aw_fire) begin
      if (!tail_open_q) begin
        q_d[tail_q].id          = aw_id_i;
        q_d[tail_q].outstanding = CntWidth'(1);
        q_d[tail_q].closed      = 1'b0;
        q_d[tail_q].err         = 1'b0;
        count_d                 = count_d + 1'b1;
        tail_open_d             = 1'b1;
      end else begin
        q_d[tail_q].outstanding =
          q_d[tail_q].outstanding + 1'b1;
      end
      if (aw_last_i) begin
        q_d[tail_q].closed = 1'b1;
        tail_open_d        = 1'b0;
        tail_d             = wrap_inc(tail_q);
      end
    end

    if (b_fire) begin
      q_d[head_q].outstanding =
        q_d[head_q].outstanding - 1'b1;
      q_d[head_q].err = q_d[head_q].err | b_err;
    end

    if ((count_d != '0) && q_d[head_q].closed &&
        (q_d[head_q].outstanding == '0)) begin
      done_valid_d = 1'b1;
      done_id_d    = q_d[head_q].id;
      done_err_d   = q_d[head_q].err;
      q_d[head_q]  = '0;
      head_d       = wrap_inc(head_q);
      count_d      = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(QueueDepth); i++) begin
        q_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      tail_open_q  <= 1'b0;
      done_valid_o <= 1'b0;
      done_id_o    <= '0;
      done_err_o   <= 1'b0;
    end else begin
      q_q          <= q_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      tail_open_q  <= tail_open_d;
      done_valid_o <= done_valid_d;
      done_id_o    <= done_id_d;
      done_err_o   <= done_err_d;
    end
  end

  a_b_expected: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    b_valid_i |-> b_ready_o
  );

  a_cnt_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(aw_fire && tail_open_q &&
      (&q_q[tail_q].outstanding))
  );

endmodule

// File: tb/tb_vstu_b_tracker.sv
// Directed bench for vstu_b_tracker.
// Expected values are hand-derived per scenario.
module tb_vstu_b_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       aw_valid_i;
  logic       aw_ready_o;
  logic [2:0] aw_id_i;
  logic       aw_last_i;
  logic       b_valid_i;
  logic [1:0] b_resp_i;
  logic       b_ready_o;
  logic       done_valid_o;
  logic [2:0] done_id_o;
  logic       done_err_o;
  logic       pending_o;

  int n_chk  = 0;
  int n_pass = 0;

  vstu_b_tracker dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .aw_valid_i   (aw_valid_i),
    .aw_ready_o   (aw_ready_o),
    .aw_id_i      (aw_id_i),
    .aw_last_i    (aw_last_i),
    .b_valid_i    (b_valid_i),
    .b_resp_i     (b_resp_i),
    .b_ready_o    (b_ready_o),
    .done_valid_o (done_valid_o),
    .done_id_o    (done_id_o),
    .done_err_o   (done_err_o),
    .pending_o    (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    aw_valid_i = 1'b0;
    aw_last_i  = 1'b0;
    b_valid_i  = 1'b0;
    b_resp_i   = 2'b00;
  endtask

  task automatic aw(input logic [2:0] id, input logic last);
    aw_valid_i = 1'b1;
    aw_id_i    = id;
    aw_last_i  = last;
    step();
    idle();
  endtask

  task automatic b(input logic [1:0] resp);
    b_valid_i = 1'b1;
    b_resp_i  = resp;
    step();
    idle();
  endtask

  task automatic done_is(
    input string tag, input logic [2:0] id, input logic err
  );
    chk({tag, ".v"}, done_valid_o, 1);
    chk({tag, ".id"}, done_id_o, id);
    chk({tag, ".err"}, done_err_o, err);
  endtask

  initial begin
    idle();
    aw_id_i = '0;
    rst_ni  = 1'b0;
    #12;
    chk("rst.aw_ready", aw_ready_o, 1);
    chk("rst.b_ready", b_ready_o, 0);
    chk("rst.pending", pending_o, 0);
    chk("rst.done", done_valid_o, 0);
    rst_ni = 1'b1;
    step();

    // single-burst store
    aw(3'd3, 1'b1);
    chk("s1.pending", pending_o, 1);
    chk("s1.b_ready", b_ready_o, 1);
    chk("s1.nodone", done_valid_o, 0);
    repeat (4) step();
    b(2'b00);
    done_is("s1", 3'd3, 1'b0);
    chk("s1.pend0", pending_o, 0);
    step();
    chk("s1.pulse", done_valid_o, 0);

    // three bursts
    aw(3'd1, 1'b0);
    aw(3'd1, 1'b0);
    aw(3'd1, 1'b1);
    b(2'b00);
    chk("s3.b1", done_valid_o, 0);
    b(2'b00);
    chk("s3.b2", done_valid_o, 0);
    b(2'b00);
    done_is("s3", 3'd1, 1'b0);
    chk("s3.b_ready", b_ready_o, 0);
    step();
    chk("s3.pulse", done_valid_o, 0);

    // early B before last burst
    aw(3'd2, 1'b0);
    b(2'b00);
    chk("eb.nodone", done_valid_o, 0);
    chk("eb.pending", pending_o, 1);
    chk("eb.b_ready", b_ready_o, 0);
    aw(3'd2, 1'b1);
    chk("eb.nodone2", done_valid_o, 0);
    chk("eb.b_ready2", b_ready_o, 1);
    b(2'b00);
    done_is("eb", 3'd2, 1'b0);

    // error merge, then clean store
    aw(3'd5, 1'b0);
    aw(3'd5, 1'b1);
    b(2'b10);
    chk("er.nodone", done_valid_o, 0);
    b(2'b00);
    done_is("er5", 3'd5, 1'b1);
    aw(3'd6, 1'b1);
    b(2'b00);
    done_is("er6", 3'd6, 1'b0);

    // backpressure at full
    for (int i = 0; i < 4; i++) aw(3'(i), 1'b1);
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd4;
    aw_last_i  = 1'b1;
    #1;
    chk("full.aw_ready", aw_ready_o, 0);
    idle();
    b(2'b00);
    done_is("full0", 3'd0, 1'b0);
    chk("full.aw_ready2", aw_ready_o, 1);
    for (int i = 1; i < 4; i++) begin
      b(2'b00);
      done_is("full_n", 3'(i), 1'b0);
    end
    chk("full.pend0", pending_o, 0);

    // AW and B on the same open entry
    aw(3'd7, 1'b0);
    aw_valid_i = 1'b1;
    aw_id_i    = 3'd7;
    aw_last_i  = 1'b0;
    b_valid_i  = 1'b1;
    step();
    idle();
    chk("sim.nodone", done_valid_o, 0);
    chk("sim.b_ready", b_ready_o, 1);
    aw_valid_i = 1'b1;
    aw_last_i  = 1'b1;
    b_valid_i  = 1'b1;
    step();
    idle();
    chk("sim.nodone2", done_valid_o, 0);
    chk("sim.b_ready2", b_ready_o, 1);
    b(2'b00);
    done_is("sim", 3'd7, 1'b0);
    step();

    // reset with two entries pending
    aw(3'd1, 1'b1);
    aw(3'd2, 1'b1);
    chk("rr.pending", pending_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rr.pend0", pending_o, 0);
    chk("rr.b_ready", b_ready_o, 0);
    chk("rr.aw_ready", aw_ready_o, 1);
    chk("rr.done", done_valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk("rr.done2", done_valid_o, 0);
    chk("rr.pend1", pending_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
